if_stage_latch_q: RTL and testbench

- Parametrised successor to the single-register IF stage latch.
- Carries {isBranchTaken, branchPC} from the branch-resolve path to the fetch stage through a DEPTH-entry queue.
- Adds a valid/ready handshake, back-pressure, and a flush, so branch redirects survive a stalled fetch stage instead of being overwritten.
- Sits between the branch-resolve logic (producer) and PC-select in IF (consumer).

---
 rtl/if_stage_latch_q.sv | 126 ++++++++++++
 tb/tb_if_stage_latch_q.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/if_stage_latch_q.sv
// ---------------------------------------------------------------------------
// if_stage_latch_q
//
// Branch-redirect queue between the branch-resolve logic (producer) and the
// PC-select mux in IF (consumer). Each entry is {isBranchTaken, branchPC}.
// A DEPTH-entry circular buffer with valid/ready on both sides lets a redirect
// wait out a stalled fetch stage instead of being overwritten, and a flush
// discards everything queued.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   rst               synchronous active-low reset (0 = reset)
//   in_valid          producer presents an entry
//   in_ready          queue has space (count != DEPTH), state-only
//   isBranchTaken     incoming entry taken flag
//   branchPC          incoming entry target PC
//   flush             synchronous discard of all entries
//   out_valid         head entry present (count != 0)
//   out_ready         consumer takes the head entry this cycle
//   isBranchTaken_out head entry flag, 0 when empty
//   branchPC_out      head entry PC, RESET_PC when empty
//   count             occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_stage_latch_q #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    isBranchTaken,
    input  logic [PC_W-1:0]         branchPC,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    isBranchTaken_out,
    output logic [PC_W-1:0]         branchPC_out,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Pointer / occupancy state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Entry storage (no reset: contents are meaningless while count says empty)
    logic             taken_q [DEPTH];
    logic             taken_d [DEPTH];
    logic [PC_W-1:0]  pc_q    [DEPTH];
    logic [PC_W-1:0]  pc_d    [DEPTH];

    logic push;
    logic pop;

    // Handshake status comes from registered occupancy only, so neither
    // ready nor valid has a combinational path from the other side.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // Head entry gated to the idle values when the queue is empty.
    always_comb begin
        isBranchTaken_out = 1'b0;
        branchPC_out      = RESET_PC;
        if (out_valid) begin
            isBranchTaken_out = taken_q[rd_ptr_q];
            branchPC_out      = pc_q[rd_ptr_q];
        end
    end

    always_comb begin
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        taken_d  = taken_q;
        pc_d     = pc_q;

        if (flush) begin
            // Flush wins over any handshake in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                taken_d[wr_ptr_q] = isBranchTaken;
                pc_d[wr_ptr_q]    = branchPC;
                // DEPTH is a power of two, so natural overflow is the wrap.
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        taken_q <= taken_d;
        pc_q    <= pc_d;
    end

endmodule

// File: tb/tb_if_stage_latch_q.sv
module tb_if_stage_latch_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A: DEPTH=2, PC_W=32 ----------------
    localparam logic [31:0] A_RP = 32'h0000_0400;

    logic        a_rst, a_iv, a_ir, a_tk, a_fl, a_ov, a_ordy, a_tko;
    logic [31:0] a_pc, a_pco;
    logic [1:0]  a_cnt;

    if_stage_latch_q #(.PC_W(32), .DEPTH(2), .RESET_PC(A_RP)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir),
        .isBranchTaken(a_tk), .branchPC(a_pc), .flush(a_fl),
        .out_valid(a_ov), .out_ready(a_ordy),
        .isBranchTaken_out(a_tko), .branchPC_out(a_pco), .count(a_cnt)
    );

    // ---------------- DUT B: DEPTH=4, PC_W=16 ----------------
    localparam logic [15:0] B_RP = 16'hBEEF;

    logic        b_rst, b_iv, b_ir, b_tk, b_fl, b_ov, b_ordy, b_tko;
    logic [15:0] b_pc, b_pco;
    logic [2:0]  b_cnt;

    if_stage_latch_q #(.PC_W(16), .DEPTH(4), .RESET_PC(B_RP)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir),
        .isBranchTaken(b_tk), .branchPC(b_pc), .flush(b_fl),
        .out_valid(b_ov), .out_ready(b_ordy),
        .isBranchTaken_out(b_tko), .branchPC_out(b_pco), .count(b_cnt)
    );

    // Producer rule on the A stimulus: a stalled entry must stay put.
    logic        a_pend    = 1'b0;
    logic        a_pend_tk = 1'b0;
    logic [31:0] a_pend_pc = '0;
    always @(posedge clk) begin
        if (a_pend)
            assert (a_iv && a_tk == a_pend_tk && a_pc == a_pend_pc)
                else $error("producer changed a stalled entry");
        a_pend    <= a_rst && !a_fl && a_iv && !a_ir;
        a_pend_tk <= a_tk;
        a_pend_pc <= a_pc;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        rst, iv, tk;
        logic [31:0] pc;
        logic        fl, ordy;
        logic        e_ir, e_ov, e_tk;
        logic [31:0] e_pc;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, iv, tk, input logic [31:0] pc, input logic fl, ordy,
                       input logic e_ir, e_ov, e_tk, input logic [31:0] e_pc, input logic [1:0] e_cnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.tk = tk; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_tk = e_tk; v.e_pc = e_pc; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // One B cycle; head value n maps to pc 16'h1000+n, taken = n[0].
    task automatic b_step(input string tag, input logic iv, input int unsigned n, input logic ordy,
                          input logic e_ov, input logic e_ir, input int unsigned e_n, input logic [2:0] e_cnt);
        logic [15:0] npc;
        logic [15:0] epc;
        npc = 16'h1000 + 16'(n);
        epc = 16'h1000 + 16'(e_n);
        b_iv = iv; b_tk = npc[0]; b_pc = npc; b_ordy = ordy;
        @(posedge clk); #1;
        check({tag, ".count"}, 32'(b_cnt), 32'(e_cnt));
        check({tag, ".out_valid"}, 32'(b_ov), 32'(e_ov));
        check({tag, ".in_ready"}, 32'(b_ir), 32'(e_ir));
        check({tag, ".pc_out"}, 32'(b_pco), e_ov ? 32'(epc) : 32'(B_RP));
        check({tag, ".tk_out"}, 32'(b_tko), e_ov ? 32'(epc[0]) : 32'd0);
    endtask

    initial begin
        a_rst = 0; a_iv = 0; a_tk = 0; a_pc = '0; a_fl = 0; a_ordy = 0;
        b_rst = 0; b_iv = 0; b_tk = 0; b_pc = '0; b_fl = 0; b_ordy = 0;

        //   rst iv tk pc      fl or | ir ov tk pc      cnt
        // reset for two edges, then idle
        add(0, 0, 0, 32'd0,   0, 0,   1, 0, 0, A_RP,   2'd0);
        add(0, 0, 0, 32'd0,   0, 0,   1, 0, 0, A_RP,   2'd0);
        add(1, 0, 0, 32'd0,   0, 0,   1, 0, 0, A_RP,   2'd0);
        // pass-through: push on empty with out_ready (pop ignored), then drain
        add(1, 1, 1, 32'd100, 0, 1,   1, 1, 1, 32'd100, 2'd1);
        add(1, 0, 0, 32'd0,   0, 1,   1, 0, 0, A_RP,   2'd0);
        add(1, 0, 0, 32'd0,   0, 1,   1, 0, 0, A_RP,   2'd0);
        // fill and back-pressure
        add(1, 1, 0, 32'd100, 0, 0,   1, 1, 0, 32'd100, 2'd1);
        add(1, 1, 1, 32'd200, 0, 0,   0, 1, 0, 32'd100, 2'd2);
        add(1, 1, 0, 32'd300, 0, 0,   0, 1, 0, 32'd100, 2'd2);
        add(1, 1, 0, 32'd300, 0, 1,   1, 1, 1, 32'd200, 2'd1);
        add(1, 1, 0, 32'd300, 0, 1,   1, 1, 0, 32'd300, 2'd1);
        add(1, 0, 0, 32'd0,   0, 1,   1, 0, 0, A_RP,   2'd0);
        // simultaneous push/pop at count=1
        add(1, 1, 1, 32'd100, 0, 0,   1, 1, 1, 32'd100, 2'd1);
        add(1, 1, 0, 32'd200, 0, 1,   1, 1, 0, 32'd200, 2'd1);
        add(1, 0, 0, 32'd0,   0, 1,   1, 0, 0, A_RP,   2'd0);
        // flush with push and pop pending
        add(1, 1, 1, 32'd100, 0, 0,   1, 1, 1, 32'd100, 2'd1);
        add(1, 1, 1, 32'd200, 0, 0,   0, 1, 1, 32'd100, 2'd2);
        add(1, 1, 1, 32'd300, 1, 1,   1, 0, 0, A_RP,   2'd0);
        add(1, 0, 0, 32'd0,   0, 1,   1, 0, 0, A_RP,   2'd0);
        // reset mid-operation with push pending
        add(1, 1, 0, 32'd100, 0, 0,   1, 1, 0, 32'd100, 2'd1);
        add(1, 1, 1, 32'd200, 0, 0,   0, 1, 0, 32'd100, 2'd2);
        add(0, 1, 1, 32'd300, 0, 1,   1, 0, 0, A_RP,   2'd0);
        add(1, 0, 0, 32'd0,   0, 0,   1, 0, 0, A_RP,   2'd0);
        // flush on empty beats a push
        add(1, 1, 1, 32'd500, 1, 0,   1, 0, 0, A_RP,   2'd0);

        foreach (vecs[i]) begin
            a_rst = vecs[i].rst; a_iv = vecs[i].iv; a_tk = vecs[i].tk;
            a_pc = vecs[i].pc; a_fl = vecs[i].fl; a_ordy = vecs[i].ordy;
            @(posedge clk); #1;
            check($sformatf("v%0d.count", i),     32'(a_cnt), 32'(vecs[i].e_cnt));
            check($sformatf("v%0d.out_valid", i), 32'(a_ov),  32'(vecs[i].e_ov));
            check($sformatf("v%0d.in_ready", i),  32'(a_ir),  32'(vecs[i].e_ir));
            check($sformatf("v%0d.tk_out", i),    32'(a_tko), 32'(vecs[i].e_tk));
            check($sformatf("v%0d.pc_out", i),    a_pco,      vecs[i].e_pc);
        end
        a_rst = 1; a_iv = 0; a_fl = 0; a_ordy = 0;

        // ---- DEPTH=4, PC_W=16: wrap after 9 push/pop pairs ----
        b_rst = 1;
        b_step("b_idle", 0, 0, 0, 0, 1, 0, 3'd0);
        b_step("b_fill1", 1, 1, 0, 1, 1, 1, 3'd1);
        b_step("b_fill2", 1, 2, 0, 1, 1, 1, 3'd2);
        b_step("b_fill3", 1, 3, 0, 1, 1, 1, 3'd3);
        for (int unsigned k = 1; k <= 9; k++)
            b_step($sformatf("b_pair%0d", k), 1, k + 3, 1, 1, 1, k + 1, 3'd3);
        // queue holds 10,11,12
        b_step("b_full", 1, 13, 0, 1, 0, 10, 3'd4);
        b_step("b_stall", 1, 14, 0, 1, 0, 10, 3'd4);
        b_step("b_full_pop", 1, 14, 1, 1, 1, 11, 3'd3);
        b_step("b_accept", 1, 14, 1, 1, 1, 12, 3'd3);
        b_step("b_drain1", 0, 0, 1, 1, 1, 13, 3'd2);
        b_step("b_drain2", 0, 0, 1, 1, 1, 14, 3'd1);
        b_step("b_drain3", 0, 0, 1, 0, 1, 0, 3'd0);
        b_step("b_underflow", 0, 0, 1, 0, 1, 0, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
